program_counter_rs: RTL and testbench
=====================================

PROGRAM_COUNTER_RS -- requirements
Module: program_counter_rs

Interface
REQ-001 Parameter WIDTH, default 15, SHALL set the program-address width in bits; legal range 2..32.
REQ-002 Parameter DEPTH, default 8, SHALL set the return-stack entry count; legal range 2..64, any integer.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 en  input  1  SHALL be the advance enable; 0 = stall, all state held.
REQ-006 inc  input  1  SHALL request out+1.
REQ-007 load  input  1  SHALL request jump: out <= in.
REQ-008 call  input  1  SHALL request subroutine call: push out+1, out <= in.
REQ-009 ret  input  1  SHALL request return: out <= top of stack, pop.
REQ-010 in  input  WIDTH  SHALL be the jump/call target.
REQ-011 clr_err  input  1  SHALL clear both sticky error flags.
REQ-012 out  output  WIDTH  SHALL be the registered current program address.
REQ-013 depth  output  $clog2(DEPTH+1)  SHALL be the registered count of valid stack entries.
REQ-014 empty  output  1  SHALL be high iff depth == 0.
REQ-015 full  output  1  SHALL be high iff depth == DEPTH.
REQ-016 overflow  output  1  SHALL be the sticky push-while-full flag.
REQ-017 underflow  output  1  SHALL be the sticky pop-while-empty flag.

Function
REQ-018 Every output SHALL be registered or decoded from registers only; no combinational path from any input to any output.
REQ-019 Priority per cycle, highest first: rst, en==0 (hold), call&ret, ret, call, load, inc, hold (out unchanged).
REQ-020 Single-cycle latency: the requested effect SHALL be visible on out/depth the cycle after the request edge.
REQ-021 All address arithmetic SHALL be modulo 2^WIDTH; out == 2^WIDTH-1 with inc gives 0; a call at that address pushes 0.
REQ-022 call, not full: stack[depth] <= out+1, depth+1, out <= in.
REQ-023 call, full: the oldest entry SHALL be discarded (circular overwrite), out+1 becomes the new top, depth stays DEPTH, overflow <= 1.
REQ-024 ret, not empty: out <= top entry, depth-1.
REQ-025 ret, empty: out unchanged, depth stays 0, underflow <= 1.
REQ-026 call&ret, not empty: top entry replaced by out+1, out <= in, depth unchanged (tail-call swap); no flag change.
REQ-027 call&ret, empty: SHALL behave exactly as call alone.
REQ-028 Stack SHALL be storage indexed by a circular top pointer mod DEPTH, so overwrite-on-full costs no data movement.
REQ-029 clr_err SHALL clear overflow and underflow next cycle; if an error event occurs in the same cycle, the flag SHALL read 1 (set wins).
REQ-030 en==0 SHALL also hold flags; clr_err SHALL be ignored while en==0.

Reset
REQ-031 On rst high, immediately and without waiting for clk: out=0, depth=0, empty=1, full=0, overflow=0, underflow=0, top pointer=0.
REQ-032 Stack storage SHALL NOT be reset; stale contents SHALL be unobservable because depth=0.
REQ-033 Reset asserted mid-call or mid-ret SHALL abort the operation with no partial stack update.
REQ-034 Deassertion SHALL be synchronised by the integrating top level; the block's first update is the first rising edge with rst low.

Verification
REQ-035 Reset, then inc x3 with en=1 -> out=3, depth=0, empty=1.
REQ-036 WIDTH=15: load in=0x7FFF, then call in=0x0100 -> out=0x0100, top=0x0000, depth=1; ret -> out=0x0000, empty=1.
REQ-037 DEPTH=8: 9 calls from out=0x10,0x20,...,0x90 -> full=1, overflow=1, depth=8; 8 rets return 0x91,0x81,...,0x21; 9th ret -> out unchanged, underflow=1.
REQ-038 depth=2, top=0x45: call&ret in=0x200 at out=0x60 -> out=0x200, top=0x61, depth=2; with empty stack, same stimulus -> depth=1, top=0x61.
REQ-039 en=0 with call=1, inc=1 for 4 cycles -> out, depth, flags unchanged; clr_err with en=1 and simultaneous ret on empty -> underflow stays 1.
REQ-040 rst pulsed between clock edges with depth=5, out=0x1234 -> out=0, depth=0, flags 0 before the next edge.

Source files
------------

// File: rtl/program_counter_rs_if.sv
// Control and status bundle between a sequencer and the program counter with return stack.
// Master drives requests and the target address; slave returns the registered address and stack status.
interface program_counter_rs_if #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
);
    logic                       en;
    logic                       inc;
    logic                       load;
    logic                       call;
    logic                       ret;
    logic [WIDTH-1:0]           in;
    logic                       clr_err;
    logic [WIDTH-1:0]           out;
    logic [$clog2(DEPTH+1)-1:0] depth;
    logic                       empty;
    logic                       full;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output en, inc, load, call, ret, in, clr_err,
        input  out, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  en, inc, load, call, ret, in, clr_err,
        output out, depth, empty, full, overflow, underflow
    );
endinterface

// File: rtl/program_counter_rs.sv
// Program counter with a circular return stack; every request takes effect one cycle after its edge.
// No backpressure: en low stalls all state, and outputs are driven purely from registers.
module program_counter_rs #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    program_counter_rs_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] stack [DEPTH];

    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic             is_empty, is_full;
    logic [PW-1:0]    top_prev, top_next;
    logic [WIDTH-1:0] pc_inc;

    // top_q is the next free slot; when full it also marks the oldest entry,
    // so a push while full overwrites it in place.
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == FULL_CNT);
    assign top_prev = (top_q == '0) ? LAST_IDX : top_q - PW'(1);
    assign top_next = (top_q == LAST_IDX) ? '0 : top_q + PW'(1);
    assign pc_inc   = pc_q + WIDTH'(1);

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        top_d   = top_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_addr = top_q;
        if (bus.en) begin
            ovf_d = ovf_q & ~bus.clr_err;
            udf_d = udf_q & ~bus.clr_err;
            if (bus.call && bus.ret && !is_empty) begin
                wr_en   = 1'b1;
                wr_addr = top_prev;
                pc_d    = bus.in;
            end else if (bus.ret && !bus.call) begin
                if (is_empty) begin
                    udf_d = 1'b1;
                end else begin
                    pc_d  = stack[top_prev];
                    top_d = top_prev;
                    cnt_d = cnt_q - DW'(1);
                end
            end else if (bus.call) begin
                wr_en   = 1'b1;
                wr_addr = top_q;
                top_d   = top_next;
                pc_d    = bus.in;
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end else if (bus.load) begin
                pc_d = bus.in;
            end else if (bus.inc) begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            cnt_q <= '0;
            top_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage is not reset; gating on rst keeps an aborted push from landing.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            stack[wr_addr] <= pc_inc;
        end
    end

    assign bus.out       = pc_q;
    assign bus.depth     = cnt_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule

// File: tb/tb_program_counter_rs.sv
// Directed bench for program_counter_rs at WIDTH=15, DEPTH=8 with hand-computed expectations.
module tb_program_counter_rs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    program_counter_rs_if #(.WIDTH(15), .DEPTH(8)) pc ();
    program_counter_rs #(.WIDTH(15), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(pc.slave));

    always #5 clk = ~clk;

    // Apply one cycle of controls, then return to idle (en=1, nothing requested) 1 time unit after the edge.
    task automatic cyc(input logic e, input logic i, input logic l, input logic c,
                       input logic r, input logic x, input logic [14:0] d);
        pc.en = e; pc.inc = i; pc.load = l; pc.call = c; pc.ret = r; pc.clr_err = x; pc.in = d;
        @(posedge clk);
        #1;
        pc.en = 1'b1; pc.inc = 1'b0; pc.load = 1'b0; pc.call = 1'b0; pc.ret = 1'b0; pc.clr_err = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        total++; if (pc.out !== 15'h0) begin bad++; $display("FAIL reset_out got %h want 0000", pc.out); end
        total++; if (pc.depth !== 4'd0) begin bad++; $display("FAIL reset_depth got %0d want 0", pc.depth); end
        total++; if ({pc.empty, pc.full, pc.overflow, pc.underflow} !== 4'b1000) begin bad++;
            $display("FAIL reset_flags got %b want 1000", {pc.empty, pc.full, pc.overflow, pc.underflow}); end
        #4 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_inc();
        for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0, 0, 15'h0);
        total++; if (pc.out !== 15'h3) begin bad++; $display("FAIL inc3_out got %h want 0003", pc.out); end
        total++; if (pc.depth !== 4'd0 || pc.empty !== 1'b1) begin bad++;
            $display("FAIL inc3_stack got depth=%0d empty=%b want 0 1", pc.depth, pc.empty); end
    endtask

    task automatic test_priority();
        cyc(1, 1, 1, 0, 0, 0, 15'h0123);
        total++; if (pc.out !== 15'h0123) begin bad++; $display("FAIL load_over_inc got %h want 0123", pc.out); end
        cyc(1, 1, 1, 1, 0, 0, 15'h0456);
        total++; if (pc.out !== 15'h0456 || pc.depth !== 4'd1) begin bad++;
            $display("FAIL call_over_load got out=%h depth=%0d want 0456 1", pc.out, pc.depth); end
        cyc(1, 1, 1, 0, 1, 0, 15'h0789);
        total++; if (pc.out !== 15'h0124 || pc.empty !== 1'b1) begin bad++;
            $display("FAIL ret_over_load got out=%h empty=%b want 0124 1", pc.out, pc.empty); end
    endtask

    task automatic test_wrap();
        cyc(1, 0, 1, 0, 0, 0, 15'h7FFF);
        cyc(1, 1, 0, 0, 0, 0, 15'h0);
        total++; if (pc.out !== 15'h0) begin bad++; $display("FAIL inc_wrap got %h want 0000", pc.out); end
        cyc(1, 0, 1, 0, 0, 0, 15'h7FFF);
        cyc(1, 0, 0, 1, 0, 0, 15'h0100);
        total++; if (pc.out !== 15'h0100 || pc.depth !== 4'd1) begin bad++;
            $display("FAIL call_wrap got out=%h depth=%0d want 0100 1", pc.out, pc.depth); end
        cyc(1, 0, 0, 0, 1, 0, 15'h0);
        total++; if (pc.out !== 15'h0 || pc.empty !== 1'b1) begin bad++;
            $display("FAIL ret_wrap got out=%h empty=%b want 0000 1", pc.out, pc.empty); end
    endtask

    task automatic test_overflow();
        logic [14:0] exp;
        do_reset();
        cyc(1, 0, 1, 0, 0, 0, 15'h0010);
        for (int k = 1; k <= 9; k++) begin
            exp = 15'(16 * (k + 1));
            cyc(1, 0, 0, 1, 0, 0, exp);
            total++; if (pc.out !== exp || pc.depth !== 4'((k > 8) ? 8 : k)) begin bad++;
                $display("FAIL push%0d got out=%h depth=%0d want %h %0d", k, pc.out, pc.depth, exp, (k > 8) ? 8 : k); end
            total++; if (pc.full !== (k >= 8) || pc.overflow !== (k == 9)) begin bad++;
                $display("FAIL push%0d_flags got full=%b ovf=%b want %b %b", k, pc.full, pc.overflow, k >= 8, k == 9); end
        end
        for (int k = 0; k < 8; k++) begin
            exp = 15'(16'h0091 - 16 * k);
            cyc(1, 0, 0, 0, 1, 0, 15'h0);
            total++; if (pc.out !== exp) begin bad++; $display("FAIL pop%0d got %h want %h", k, pc.out, exp); end
        end
        total++; if (pc.empty !== 1'b1 || pc.underflow !== 1'b0) begin bad++;
            $display("FAIL drained got empty=%b udf=%b want 1 0", pc.empty, pc.underflow); end
        cyc(1, 0, 0, 0, 1, 0, 15'h0);
        total++; if (pc.out !== 15'h0021 || pc.depth !== 4'd0 || pc.underflow !== 1'b1 || pc.overflow !== 1'b1) begin bad++;
            $display("FAIL pop_empty got out=%h depth=%0d udf=%b ovf=%b want 0021 0 1 1", pc.out, pc.depth, pc.underflow, pc.overflow); end
        cyc(1, 0, 0, 0, 0, 1, 15'h0);
        total++; if (pc.overflow !== 1'b0 || pc.underflow !== 1'b0) begin bad++;
            $display("FAIL clr_err got ovf=%b udf=%b want 0 0", pc.overflow, pc.underflow); end
    endtask

    task automatic test_tail_call();
        do_reset();
        cyc(1, 0, 1, 0, 0, 0, 15'h0040);
        cyc(1, 0, 0, 1, 0, 0, 15'h0044);
        cyc(1, 0, 0, 1, 0, 0, 15'h0060);
        cyc(1, 0, 0, 1, 1, 0, 15'h0200);
        total++; if (pc.out !== 15'h0200 || pc.depth !== 4'd2 || pc.overflow !== 1'b0 || pc.underflow !== 1'b0) begin bad++;
            $display("FAIL swap got out=%h depth=%0d ovf=%b udf=%b want 0200 2 0 0", pc.out, pc.depth, pc.overflow, pc.underflow); end
        cyc(1, 0, 0, 0, 1, 0, 15'h0);
        total++; if (pc.out !== 15'h0061) begin bad++; $display("FAIL swap_top got %h want 0061", pc.out); end
        cyc(1, 0, 0, 0, 1, 0, 15'h0);
        total++; if (pc.out !== 15'h0041 || pc.empty !== 1'b1) begin bad++;
            $display("FAIL swap_below got out=%h empty=%b want 0041 1", pc.out, pc.empty); end
        cyc(1, 0, 1, 0, 0, 0, 15'h0060);
        cyc(1, 0, 0, 1, 1, 0, 15'h0200);
        total++; if (pc.out !== 15'h0200 || pc.depth !== 4'd1 || pc.underflow !== 1'b0) begin bad++;
            $display("FAIL swap_empty got out=%h depth=%0d udf=%b want 0200 1 0", pc.out, pc.depth, pc.underflow); end
        cyc(1, 0, 0, 0, 1, 0, 15'h0);
        total++; if (pc.out !== 15'h0061) begin bad++; $display("FAIL swap_empty_top got %h want 0061", pc.out); end
    endtask

    task automatic test_stall();
        cyc(1, 0, 0, 0, 1, 0, 15'h0);
        total++; if (pc.underflow !== 1'b1 || pc.out !== 15'h0061) begin bad++;
            $display("FAIL stall_setup got udf=%b out=%h want 1 0061", pc.underflow, pc.out); end
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 1, 0, (k == 3), 15'h0333);
            total++; if (pc.out !== 15'h0061 || pc.depth !== 4'd0 || pc.underflow !== 1'b1 || pc.overflow !== 1'b0) begin bad++;
                $display("FAIL stall%0d got out=%h depth=%0d udf=%b ovf=%b want 0061 0 1 0", k, pc.out, pc.depth, pc.underflow, pc.overflow); end
        end
        cyc(1, 0, 0, 0, 1, 1, 15'h0);
        total++; if (pc.underflow !== 1'b1 || pc.out !== 15'h0061) begin bad++;
            $display("FAIL set_wins got udf=%b out=%h want 1 0061", pc.underflow, pc.out); end
        cyc(1, 0, 0, 0, 0, 1, 15'h0);
        total++; if (pc.underflow !== 1'b0) begin bad++; $display("FAIL udf_clear got %b want 0", pc.underflow); end
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 0, 0, 1, 0, 15'h0);
        cyc(1, 0, 1, 0, 0, 0, 15'h1000);
        for (int k = 1; k <= 5; k++) cyc(1, 0, 0, 1, 0, 0, (k == 5) ? 15'h1234 : 15'(16'h1000 + 16'h0100 * k));
        total++; if (pc.out !== 15'h1234 || pc.depth !== 4'd5 || pc.underflow !== 1'b1) begin bad++;
            $display("FAIL arst_setup got out=%h depth=%0d udf=%b want 1234 5 1", pc.out, pc.depth, pc.underflow); end
        #2 rst = 1'b1;
        #1;
        total++; if (pc.out !== 15'h0 || pc.depth !== 4'd0 || {pc.empty, pc.full, pc.overflow, pc.underflow} !== 4'b1000) begin bad++;
            $display("FAIL arst_now got out=%h depth=%0d flags=%b want 0000 0 1000", pc.out, pc.depth,
                     {pc.empty, pc.full, pc.overflow, pc.underflow}); end
        #3 rst = 1'b0;
        cyc(1, 1, 0, 0, 0, 0, 15'h0);
        total++; if (pc.out !== 15'h1) begin bad++; $display("FAIL arst_first_edge got %h want 0001", pc.out); end
        // Reset held across an edge carrying a call must leave the stack untouched.
        pc.call = 1'b1; pc.in = 15'h0555;
        #2 rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; pc.call = 1'b0;
        total++; if (pc.out !== 15'h0 || pc.depth !== 4'd0) begin bad++;
            $display("FAIL arst_abort got out=%h depth=%0d want 0000 0", pc.out, pc.depth); end
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 1, 0, 15'h0);
        total++; if (pc.out !== 15'h0 || pc.underflow !== 1'b1) begin bad++;
            $display("FAIL arst_abort_pop got out=%h udf=%b want 0000 1", pc.out, pc.underflow); end
    endtask

    initial begin
        pc.en = 1'b1; pc.inc = 1'b0; pc.load = 1'b0; pc.call = 1'b0; pc.ret = 1'b0;
        pc.clr_err = 1'b0; pc.in = 15'h0;
        #1;
        test_reset();
        test_inc();
        test_priority();
        test_wrap();
        test_overflow();
        test_tail_call();
        test_stall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
